// File: rtl/regfile_pkg.sv
// Shared definitions for the 32-entry register file.
// Holds the array geometry, the address and one-hot write-enable types, and
// the forwarding-match helper that the optional write-through path uses.
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;

  typedef logic [ADDR_W-1:0]    reg_addr_t;
  typedef logic [REG_COUNT-1:0] reg_onehot_t;

  // True when a read port should take the in-flight write data rather than
  // the stored value. Index 0 never forwards because it is hardwired to zero.
  function automatic logic bypass_hit(input logic      wr_ena,
                                      input reg_addr_t wr_addr,
                                      input reg_addr_t rd_addr);
    return wr_ena && (wr_addr != '0) && (rd_addr == wr_addr);
  endfunction

endpackage

// File: rtl/register_file_decoder.sv
// Write-address decoder tree for the register file.
// decoder_5_to_32 is built from one decoder_2_to_4, which selects a group of
// eight registers, feeding the enables of four decoder_3_to_8 leaves. With
// ena low every output is zero regardless of the address, so an undriven
// address cannot cause a spurious write.
import regfile_pkg::*;

module decoder_2_to_4 (
  input  logic [1:0] sel,
  input  logic       ena,
  output logic [3:0] dec
);

  // Drive exactly one output high when enabled, none otherwise.
  always_comb begin
    dec = '0;
    if (ena) begin
      dec[sel] = 1'b1;
    end
  end

endmodule

module decoder_3_to_8 (
  input  logic [2:0] sel,
  input  logic       ena,
  output logic [7:0] dec
);

  // Drive exactly one output high when enabled, none otherwise.
  always_comb begin
    dec = '0;
    if (ena) begin
      dec[sel] = 1'b1;
    end
  end

endmodule

module decoder_5_to_32 (
  input  reg_addr_t   addr,
  input  logic        ena,
  output reg_onehot_t onehot
);

  logic [3:0] grp_ena;

  decoder_2_to_4 u_grp (
    .sel (addr[4:3]),
    .ena (ena),
    .dec (grp_ena)
  );

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    decoder_3_to_8 u_leaf (
      .sel (addr[2:0]),
      .ena (grp_ena[g]),
      .dec (onehot[g*8 +: 8])
    );
  end

endmodule

// File: rtl/register_file.sv
// 32-entry x N-bit register file with two combinational read ports and one
// synchronous write port, feeding ALU operands A and B.
// Register 0 is hardwired to zero and has no storage.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read of the register being written returns wr_data in the
//                same cycle (suppressed while rst is high)
//   undefined -> reads show the stored value until the write edge commits.
import regfile_pkg::*;

module register_file #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  reg_addr_t    wr_addr,
  input  logic [N-1:0] wr_data,
  input  reg_addr_t    rd_addr0,
  output logic [N-1:0] rd_data0,
  input  reg_addr_t    rd_addr1,
  output logic [N-1:0] rd_data1
);

  reg_onehot_t  wr_en_1h;
  logic [N-1:0] regs [REG_COUNT];
  logic [N-1:0] mux_data0;
  logic [N-1:0] mux_data1;
  logic         unused_wr_en_r0;

  decoder_5_to_32 u_wr_dec (
    .addr   (wr_addr),
    .ena    (wr_ena),
    .onehot (wr_en_1h)
  );

  // Index 0 has no flop, so its decoder output is deliberately left unused.
  assign unused_wr_en_r0 = wr_en_1h[0];
  assign regs[0]         = '0;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    logic [N-1:0] q;

    // Each register clears immediately on rst and otherwise loads wr_data
    // on the edge where its one-hot enable is set; rst wins over a write.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (wr_en_1h[i]) begin
        q <= wr_data;
      end
    end

    assign regs[i] = q;
  end

  // Port 0 stored-value mux; index 0 forced to zero explicitly.
  always_comb begin
    mux_data0 = regs[rd_addr0];
    if (rd_addr0 == '0) begin
      mux_data0 = '0;
    end
  end

  // Port 1 stored-value mux; index 0 forced to zero explicitly.
  always_comb begin
    mux_data1 = regs[rd_addr1];
    if (rd_addr1 == '0) begin
      mux_data1 = '0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write to any port reading the same register, so
  // the ALU sees the new value in the same cycle. Disabled during reset.
  always_comb begin
    rd_data0 = mux_data0;
    rd_data1 = mux_data1;
    if (!rst && bypass_hit(wr_ena, wr_addr, rd_addr0)) begin
      rd_data0 = wr_data;
    end
    if (!rst && bypass_hit(wr_ena, wr_addr, rd_addr1)) begin
      rd_data1 = wr_data;
    end
  end
`else
  // Without forwarding the ports show the committed register contents only.
  always_comb begin
    rd_data0 = mux_data0;
    rd_data1 = mux_data1;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reset behaviour, a table of directed
// write/read vectors, hand-written multi-cycle corner cases and a short
// randomised run against a scoreboard array.
module tb_register_file;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         wr_ena;
  logic [4:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic [4:0]   rd_addr0;
  logic [N-1:0] rd_data0;
  logic [4:0]   rd_addr1;
  logic [N-1:0] rd_data1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         we;
    logic [4:0]   wa;
    logic [N-1:0] wd;
    logic [4:0]   ra0;
    logic [4:0]   ra1;
    logic [N-1:0] exp0;
    logic [N-1:0] exp1;
  } vec_t;

  localparam int NUM_VECS = 18;
  vec_t vecs [NUM_VECS];

  logic [N-1:0] sb [32];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one read port value against the bench's expectation.
  task automatic checkOne(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Compare both read ports.
  task automatic checkOutput(input string name, input logic [N-1:0] exp0, input logic [N-1:0] exp1);
    checkOne({name, ".p0"}, rd_data0, exp0);
    checkOne({name, ".p1"}, rd_data1, exp1);
  endtask

  // Drive a write plus read addresses on the falling edge, let one rising
  // edge commit it, then drop the strobe so the reads show stored values.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [N-1:0] wd,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    wr_ena   = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr0 = ra0;
    rd_addr1 = ra1;
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    #1;
  endtask

  initial begin
    // Directed vectors, applied in order starting from an all-zero file.
    vecs[0]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
    vecs[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h00000000, 32'h12345678};
    vecs[2]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd0,  5'd31, 32'h00000000, 32'hA5A5A5A5};
    vecs[3]  = '{1'b1, 5'd3,  32'h00000011, 5'd3,  5'd31, 32'h00000011, 32'hA5A5A5A5};
    vecs[4]  = '{1'b0, 5'd3,  32'hCAFE0000, 5'd3,  5'd7,  32'h00000011, 32'h12345678};
    vecs[5]  = '{1'b0, 5'd3,  32'hCAFE0000, 5'd3,  5'd7,  32'h00000011, 32'h12345678};
    vecs[6]  = '{1'b0, 5'd3,  32'hCAFE0000, 5'd3,  5'd7,  32'h00000011, 32'h12345678};
    vecs[7]  = '{1'b0, 5'd3,  32'hCAFE0000, 5'd3,  5'd7,  32'h00000011, 32'h12345678};
    vecs[8]  = '{1'b0, 5'd3,  32'hCAFE0000, 5'd3,  5'd7,  32'h00000011, 32'h12345678};
    vecs[9]  = '{1'b1, 5'd9,  32'h00000001, 5'd9,  5'd3,  32'h00000001, 32'h00000011};
    vecs[10] = '{1'b1, 5'd31, 32'h00000BEE, 5'd31, 5'd9,  32'h00000BEE, 32'h00000001};
    vecs[11] = '{1'b1, 5'd1,  32'hFFFFFFFF, 5'd1,  5'd2,  32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{1'b1, 5'd30, 32'h80000001, 5'd30, 5'd1,  32'h80000001, 32'hFFFFFFFF};
    vecs[13] = '{1'b1, 5'd8,  32'h00000008, 5'd8,  5'd16, 32'h00000008, 32'h00000000};
    vecs[14] = '{1'b1, 5'd16, 32'h00000016, 5'd16, 5'd8,  32'h00000016, 32'h00000008};
    vecs[15] = '{1'b1, 5'd24, 32'h00000024, 5'd24, 5'd23, 32'h00000024, 32'h00000000};
    vecs[16] = '{1'b1, 5'd23, 32'h00000023, 5'd23, 5'd24, 32'h00000023, 32'h00000024};
    vecs[17] = '{1'b1, 5'd2,  32'h0000F00D, 5'd2,  5'd6,  32'h0000F00D, 32'h00000000};

    rst      = 1'b1;
    wr_ena   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr0 = 5'd5;
    rd_addr1 = 5'd31;
    #3;
    checkOutput("reset_state", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-cycle clears a freshly written register before any edge.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    checkOutput("r5_written", 32'hDEADBEEF, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 32'h0, 32'h0);

    // A write presented while reset is high must not land.
    @(negedge clk);
    wr_ena  = 1'b1;
    wr_addr = 5'd6;
    wr_data = 32'h66666666;
    rd_addr0 = 5'd6;
    rd_addr1 = 5'd5;
    #1;
    checkOutput("rst_no_bypass", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    wr_ena = 1'b0;
    rst    = 1'b0;
    #1;
    checkOutput("rst_blocks_write", 32'h0, 32'h0);

    // Directed table.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp0, vecs[i].exp1);
    end

    // Same-cycle read of the register being written (r9 holds 1).
    @(negedge clk);
    wr_ena   = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h00000002;
    rd_addr0 = 5'd9;
    rd_addr1 = 5'd3;
    #1;
    checkOutput("pre_edge_r9", BYPASS ? 32'h2 : 32'h1, 32'h00000011);
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    #1;
    checkOutput("post_edge_r9", 32'h2, 32'h00000011);

    // Writing index 0 never forwards, even with the same read address.
    @(negedge clk);
    wr_ena   = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'h77777777;
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd9;
    #1;
    checkOutput("r0_no_bypass", 32'h0, 32'h2);
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    #1;
    checkOutput("r0_after_edge", 32'h0, 32'h2);

    // Back-to-back writes to one index: last edge wins.
    @(negedge clk);
    wr_ena   = 1'b1;
    wr_addr  = 5'd12;
    wr_data  = 32'h0000AAAA;
    rd_addr0 = 5'd12;
    rd_addr1 = 5'd12;
    @(posedge clk);
    @(negedge clk);
    wr_data = 32'h0000BBBB;
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    #1;
    checkOutput("back_to_back", 32'h0000BBBB, 32'h0000BBBB);

    // Strobe low with arbitrary address/data leaves state untouched.
    @(negedge clk);
    wr_addr  = 5'd7;
    wr_data  = 32'hBAD0BAD0;
    rd_addr0 = 5'd7;
    rd_addr1 = 5'd24;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ena_low_hold", 32'h12345678, 32'h00000024);

    // Randomised run against a scoreboard primed with the known contents.
    for (int r = 0; r < 32; r++) sb[r] = '0;
    sb[1] = 32'hFFFFFFFF; sb[2] = 32'h0000F00D; sb[3] = 32'h00000011;
    sb[7] = 32'h12345678; sb[8] = 32'h00000008; sb[9] = 32'h2;
    sb[12] = 32'h0000BBBB; sb[16] = 32'h00000016; sb[23] = 32'h00000023;
    sb[24] = 32'h00000024; sb[30] = 32'h80000001; sb[31] = 32'h00000BEE;
    for (int it = 0; it < 1500; it++) begin
      logic [N-1:0] e0;
      logic [N-1:0] e1;
      @(negedge clk);
      wr_ena   = ($urandom_range(0, 3) != 0);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr1 = 5'($urandom_range(0, 31));
      e0 = (rd_addr0 == 5'd0) ? '0 : sb[rd_addr0];
      e1 = (rd_addr1 == 5'd0) ? '0 : sb[rd_addr1];
      if (BYPASS && wr_ena && wr_addr != 5'd0 && rd_addr0 == wr_addr) e0 = wr_data;
      if (BYPASS && wr_ena && wr_addr != 5'd0 && rd_addr1 == wr_addr) e1 = wr_data;
      #1;
      checkOutput($sformatf("rand%0d", it), e0, e1);
      @(posedge clk);
      if (wr_ena && wr_addr != 5'd0) sb[wr_addr] = wr_data;
    end
    @(negedge clk);
    wr_ena = 1'b0;

    // Final mid-cycle reset must clear every register.
    #2;
    rst = 1'b1;
    for (int r = 0; r < 32; r++) begin
      rd_addr0 = 5'(r);
      rd_addr1 = 5'(31 - r);
      #1;
      checkOutput($sformatf("final_rst%0d", r), 32'h0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
